pipeline_ctrl: RTL and testbench

- Central hazard and flush controller for the 6-stage MIPS pipeline: PC, IF, ID, EX, MEM, WB.
- It is the producer side of the stall[5:0] bus consumed by every inter-stage register.
  - Example: the ID/EX register inserts a bubble when stall[2]=1 and stall[3]=0.
- Arbitrates per-stage stall requests and exception flush requests.
- Sequences a flush/redirect, detects stall deadlock, and counts stall cycles for performance analysis.

---
 rtl/pipeline_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller for the 6-stage pipeline: drives the stall vector,
// sequences exception redirects, flags stall deadlock and counts stall cycles.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state, state_next;
    logic [15:0] consec, consec_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            new_pc        <= '0;
            consec        <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state  <= state_next;
            consec <= consec_next;
            if (flush_req)
                new_pc <= flush_pc;
            if (consec_next == TIMEOUT_W)
                stall_timeout <= 1'b1;
            if (stall[0] && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // flush comes straight from the state register, never from flush_req
    assign flush = (state == FLUSH);

    always_comb begin
        state_next = state;
        stall      = '0;
        unique case (state)
            RUN: begin
                if (stallreq_mem)     stall = 6'b011111;
                else if (stallreq_ex) stall = 6'b001111;
                else if (stallreq_id) stall = 6'b000111;
                else if (stallreq_if) stall = 6'b000011;
                if (flush_req) state_next = FLUSH;
            end
            FLUSH: begin
                state_next = flush_req ? FLUSH : REFILL;
            end
            REFILL: begin
                if (stallreq_if) stall = 6'b000011;
                state_next = flush_req ? FLUSH : RUN;
            end
            default: state_next = RUN;
        endcase
        if (rst) stall = '0;
    end

    always_comb begin
        consec_next = consec;
        if (flush || !stall[0])
            consec_next = '0;
        else if (consec != TIMEOUT_W)
            consec_next = consec + 16'd1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with small TIMEOUT and counter width
// so deadlock detection and counter saturation are reachable quickly.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [3:0]  stall_cycles;

    int vectors = 0;
    int errors  = 0;

    pipeline_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        flush_req = 0; flush_pc = '0;
    endtask

    task automatic do_reset();
        rst = 1; clear_reqs(); tick(); rst = 0; #1;
    endtask

    task automatic test_reset();
        rst = 1;
        stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
        flush_req = 1; flush_pc = 32'hDEADBEEF;
        #1;
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall, 6'b0); end
        tick(); tick();
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall2: got %b expected %b", stall, 6'b0); end
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
        vectors++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc: got %h expected 0", new_pc); end
        vectors++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", stall_timeout); end
        vectors++; if (stall_cycles !== 4'h0) begin errors++; $display("FAIL reset_cycles: got %h expected 0", stall_cycles); end
        rst = 0; clear_reqs(); tick();
    endtask

    task automatic test_priority();
        stallreq_if = 1; #1;
        vectors++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if: got %b expected %b", stall, 6'b000011); end
        stallreq_if = 0; stallreq_id = 1; #1;
        vectors++; if (stall !== 6'b000111) begin errors++; $display("FAIL prio_id: got %b expected %b", stall, 6'b000111); end
        stallreq_ex = 1; #1;
        vectors++; if (stall !== 6'b001111) begin errors++; $display("FAIL prio_ex: got %b expected %b", stall, 6'b001111); end
        stallreq_mem = 1; stallreq_if = 1; #1;
        vectors++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem: got %b expected %b", stall, 6'b011111); end
        clear_reqs(); #1;
        vectors++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_none: got %b expected %b", stall, 6'b0); end
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL prio_flush: got %b expected 0", flush); end
    endtask

    task automatic test_flush();
        do_reset();
        stallreq_ex = 1; flush_req = 1; flush_pc = 32'hBFC00380; #1;
        vectors++; if (stall !== 6'b001111) begin errors++; $display("FAIL flush_req_stall: got %b expected %b", stall, 6'b001111); end
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_not_comb: got %b expected 0", flush); end
        tick(); flush_req = 0; flush_pc = 32'h0; #1;
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_n1: got %b expected 1", flush); end
        vectors++; if (new_pc !== 32'hBFC00380) begin errors++; $display("FAIL flush_pc_n1: got %h expected %h", new_pc, 32'hBFC00380); end
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL flush_stall_n1: got %b expected %b", stall, 6'b0); end
        tick();
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_n2: got %b expected 0", flush); end
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL flush_stall_n2: got %b expected %b", stall, 6'b0); end
        vectors++; if (new_pc !== 32'hBFC00380) begin errors++; $display("FAIL flush_pc_hold: got %h expected %h", new_pc, 32'hBFC00380); end
        tick();
        vectors++; if (stall !== 6'b001111) begin errors++; $display("FAIL flush_stall_n3: got %b expected %b", stall, 6'b001111); end
        clear_reqs();
    endtask

    task automatic test_refill_if();
        do_reset();
        stallreq_if = 1; stallreq_mem = 1; flush_req = 1; flush_pc = 32'h00001000;
        tick(); flush_req = 0; #1;
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL refill_flush_stall: got %b expected %b", stall, 6'b0); end
        tick();
        vectors++; if (stall !== 6'b000011) begin errors++; $display("FAIL refill_if_only: got %b expected %b", stall, 6'b000011); end
        stallreq_if = 0; #1;
        vectors++; if (stall !== 6'b000000) begin errors++; $display("FAIL refill_no_if: got %b expected %b", stall, 6'b0); end
        tick();
        vectors++; if (stall !== 6'b011111) begin errors++; $display("FAIL refill_back_run: got %b expected %b", stall, 6'b011111); end
        clear_reqs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        flush_req = 1; flush_pc = 32'h80000180;
        tick(); flush_pc = 32'h80000200; #1;
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush_n1: got %b expected 1", flush); end
        vectors++; if (new_pc !== 32'h80000180) begin errors++; $display("FAIL b2b_pc_n1: got %h expected %h", new_pc, 32'h80000180); end
        tick(); flush_req = 0; #1;
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush_n2: got %b expected 1", flush); end
        vectors++; if (new_pc !== 32'h80000200) begin errors++; $display("FAIL b2b_pc_n2: got %h expected %h", new_pc, 32'h80000200); end
        tick();
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush_n3: got %b expected 0", flush); end
        // re-arm from REFILL
        flush_req = 1; flush_pc = 32'h80000300;
        tick(); flush_req = 0; #1;
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL rearm_refill: got %b expected 1", flush); end
        vectors++; if (new_pc !== 32'h80000300) begin errors++; $display("FAIL rearm_pc: got %h expected %h", new_pc, 32'h80000300); end
        tick(); tick(); clear_reqs();
    endtask

    task automatic test_timeout();
        do_reset();
        // a one-cycle gap must restart the consecutive count
        stallreq_mem = 1;
        for (int i = 0; i < 5; i++) tick();
        stallreq_mem = 0; tick(); stallreq_mem = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early%0d: got %b expected 0", i, stall_timeout); end
        end
        tick();
        vectors++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_8th: got %b expected 1", stall_timeout); end
        stallreq_mem = 0; tick(); tick();
        vectors++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", stall_timeout); end
        rst = 1; tick(); rst = 0; #1;
        vectors++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL timeout_rst: got %b expected 0", stall_timeout); end
    endtask

    task automatic test_saturation();
        do_reset();
        stallreq_id = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                vectors++; if (stall_cycles !== 4'hE) begin errors++; $display("FAIL cycles_14: got %h expected %h", stall_cycles, 4'hE); end
            end
        end
        vectors++; if (stall_cycles !== 4'hF) begin errors++; $display("FAIL cycles_sat: got %h expected %h", stall_cycles, 4'hF); end
        stallreq_id = 0; rst = 1; tick(); rst = 0; #1;
        vectors++; if (stall_cycles !== 4'h0) begin errors++; $display("FAIL cycles_rst: got %h expected 0", stall_cycles); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        flush_req = 1; flush_pc = 32'h12345678;
        tick(); flush_req = 0; #1;
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL rmf_flush: got %b expected 1", flush); end
        rst = 1; stallreq_if = 1; stallreq_mem = 1;
        tick();
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL rmf_flush_rst: got %b expected 0", flush); end
        vectors++; if (new_pc !== 32'h0) begin errors++; $display("FAIL rmf_new_pc: got %h expected 0", new_pc); end
        vectors++; if (stall !== 6'b0) begin errors++; $display("FAIL rmf_stall_rst: got %b expected %b", stall, 6'b0); end
        rst = 0; #1;
        vectors++; if (stall !== 6'b011111) begin errors++; $display("FAIL rmf_state_run: got %b expected %b", stall, 6'b011111); end
        tick();
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL rmf_no_pulse: got %b expected 0", flush); end
        clear_reqs();
    endtask

    initial begin
        rst = 1; clear_reqs();
        test_reset();
        test_priority();
        test_flush();
        test_refill_if();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
